// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit lookahead group per
// register stage, group carry registered between stages, valid/ready at both ends.
module cla_addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NGRP = WIDTH / BLOCK;

    // Returns {group carry-out, carry into group MSB, group sum}; every carry is a
    // flat sum of generate/propagate products rather than a rippled chain.
    function automatic logic [BLOCK+1:0] groupAdd(input logic [BLOCK-1:0] a,
                                                  input logic [BLOCK-1:0] b,
                                                  input logic c0);
        logic [BLOCK-1:0] p;
        logic [BLOCK-1:0] g;
        logic [BLOCK:0]   c;
        logic             term;
        p    = a ^ b;
        g    = a & b;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < BLOCK; i++) begin
            term = c0;
            for (int j = 0; j <= i; j++) term = term & p[j];
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) term = term & p[k];
                c[i+1] = c[i+1] | term;
            end
        end
        return {c[BLOCK], c[BLOCK-1], p ^ c[BLOCK-1:0]};
    endfunction

    logic [NGRP-1:0]  validQ, validD;
    logic [NGRP-1:0]  carryQ, carryD;
    logic [WIDTH-1:0] aQ   [NGRP];
    logic [WIDTH-1:0] aD   [NGRP];
    logic [WIDTH-1:0] bQ   [NGRP];
    logic [WIDTH-1:0] bD   [NGRP];
    logic [WIDTH-1:0] sumQ [NGRP];
    logic [WIDTH-1:0] sumD [NGRP];
    logic             ovfQ, ovfD;

    logic [WIDTH-1:0] stgA   [NGRP];
    logic [WIDTH-1:0] stgB   [NGRP];
    logic [WIDTH-1:0] stgSum [NGRP];
    logic [NGRP-1:0]  stgC;
    logic [NGRP-1:0]  stgV;
    logic [BLOCK+1:0] grpRes [NGRP];
    logic             en;

    assign en       = ~validQ[NGRP-1] | out_ready;
    assign in_ready = en;

    // Stage 0 is fed by the ports with B and carry-in already inverted for
    // subtraction; every later stage is fed by the registers of the stage before.
    always_comb begin
        stgA[0]   = in1;
        stgB[0]   = sub ? ~in2 : in2;
        stgC[0]   = cin ^ sub;
        stgV[0]   = in_valid;
        stgSum[0] = '0;
        for (int k = 1; k < NGRP; k++) begin
            stgA[k]   = aQ[k-1];
            stgB[k]   = bQ[k-1];
            stgC[k]   = carryQ[k-1];
            stgV[k]   = validQ[k-1];
            stgSum[k] = sumQ[k-1];
        end
    end

    always_comb begin
        ovfD = 1'b0;
        for (int k = 0; k < NGRP; k++) begin
            grpRes[k]                  = groupAdd(stgA[k][k*BLOCK +: BLOCK],
                                                  stgB[k][k*BLOCK +: BLOCK], stgC[k]);
            sumD[k]                    = stgSum[k];
            sumD[k][k*BLOCK +: BLOCK]  = grpRes[k][BLOCK-1:0];
            carryD[k]                  = grpRes[k][BLOCK+1];
            validD[k]                  = stgV[k];
            aD[k]                      = stgA[k];
            bD[k]                      = stgB[k];
        end
        ovfD = grpRes[NGRP-1][BLOCK+1] ^ grpRes[NGRP-1][BLOCK];
    end

    // The whole pipe advances together; with a stalled output every stage holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            validQ <= '0;
            carryQ <= '0;
            ovfQ   <= 1'b0;
            for (int k = 0; k < NGRP; k++) begin
                aQ[k]   <= '0;
                bQ[k]   <= '0;
                sumQ[k] <= '0;
            end
        end else if (en) begin
            validQ <= validD;
            carryQ <= carryD;
            ovfQ   <= ovfD;
            for (int k = 0; k < NGRP; k++) begin
                aQ[k]   <= aD[k];
                bQ[k]   <= bD[k];
                sumQ[k] <= sumD[k];
            end
        end
    end

    assign out_valid = validQ[NGRP-1];
    assign out       = sumQ[NGRP-1];
    assign cout      = carryQ[NGRP-1];
    assign ovf       = ovfQ;
    assign zero      = ~|sumQ[NGRP-1];

endmodule
